// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration among the
// writeback sources, one registered write per cycle, and a pending-write
// scoreboard for r1..r31 that decode uses for RAW/WAW hazard detection.

// One scoreboard bit: set by a decode reservation, cleared by the granted write.
module regfile_write_scheduler_sb_cell (
    input  logic clock,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic pending
);
    // A reservation and a clear on the same edge keep the bit set, because
    // the reservation belongs to the newer producer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pending <= 1'b0;
        else if (set)
            pending <= 1'b1;
        else if (clr)
            pending <= 1'b0;
    end
endmodule

module regfile_write_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0][4:0]               req_address,
    input  logic [NUM_REQ-1:0][3:0]               req_strobe,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data,
    output logic                                  write_enabled,
    output logic [4:0]                            write_address,
    output logic [3:0]                            write_strobe,
    output logic [DATA_WIDTH-1:0]                 write_data,
    input  logic                                  reserve_valid,
    input  logic [4:0]                            reserve_address,
    output logic                                  reserve_conflict,
    input  logic [4:0]                            query_address_1,
    output logic                                  query_pending_1,
    input  logic [4:0]                            query_address_2,
    output logic                                  query_pending_2
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_pointer;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             transfer;
    logic [4:0]       grant_address;
    logic [3:0]       grant_strobe;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [31:0]      pending;

    // Round-robin scan starting at rr_pointer; first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_pointer) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    // Grants are suppressed while reset is held so no source thinks it was taken.
    assign transfer = grant_any & reset_n;

    // One-hot ready toward the granted requester.
    always_comb begin
        req_ready = '0;
        if (transfer)
            req_ready[grant_idx] = 1'b1;
    end

    assign grant_address = req_address[grant_idx];
    assign grant_strobe  = req_strobe[grant_idx];
    assign grant_data    = req_data[grant_idx];

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rr_pointer <= '0;
        else if (transfer)
            rr_pointer <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Registered write port: capture the winner, suppress writes to r0 or with no strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_enabled <= 1'b0;
            write_address <= '0;
            write_strobe  <= '0;
            write_data    <= '0;
        end else if (transfer) begin
            write_enabled <= (grant_address != 5'd0) && (grant_strobe != 4'd0);
            write_address <= grant_address;
            write_strobe  <= grant_strobe;
            write_data    <= grant_data;
        end else begin
            write_enabled <= 1'b0;
        end
    end

    // r0 is hardwired and never pending.
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_sb
        regfile_write_scheduler_sb_cell u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .set     (reserve_valid && (reserve_address == 5'(r))),
            .clr     (transfer && (grant_address == 5'(r))),
            .pending (pending[r])
        );
    end

    // Lookups see the registered scoreboard only; same-cycle set/clear is not bypassed.
    assign reserve_conflict = pending[reserve_address];
    assign query_pending_1  = pending[query_address_1];
    assign query_pending_2  = pending[query_address_2];
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed-vector bench for regfile_write_scheduler.
module tb_regfile_write_scheduler;
    localparam int NUM_REQ = 3;
    localparam int DW      = 32;

    logic                          clock = 1'b0;
    logic                          reset_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][4:0]       req_address;
    logic [NUM_REQ-1:0][3:0]       req_strobe;
    logic [NUM_REQ-1:0][DW-1:0]    req_data;
    logic                          write_enabled;
    logic [4:0]                    write_address;
    logic [3:0]                    write_strobe;
    logic [DW-1:0]                 write_data;
    logic                          reserve_valid;
    logic [4:0]                    reserve_address;
    logic                          reserve_conflict;
    logic [4:0]                    query_address_1;
    logic                          query_pending_1;
    logic [4:0]                    query_address_2;
    logic                          query_pending_2;

    int nvec = 0;
    int nmis = 0;

    regfile_write_scheduler #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_address      (req_address),
        .req_strobe       (req_strobe),
        .req_data         (req_data),
        .write_enabled    (write_enabled),
        .write_address    (write_address),
        .write_strobe     (write_strobe),
        .write_data       (write_data),
        .reserve_valid    (reserve_valid),
        .reserve_address  (reserve_address),
        .reserve_conflict (reserve_conflict),
        .query_address_1  (query_address_1),
        .query_pending_1  (query_pending_1),
        .query_address_2  (query_address_2),
        .query_pending_2  (query_pending_2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        req_valid       = '0;
        req_address     = '0;
        req_strobe      = '0;
        req_data        = '0;
        reserve_valid   = 1'b0;
        reserve_address = '0;
        query_address_1 = '0;
        query_address_2 = '0;

        // Reset state, with a requester asserting valid during reset
        tick();
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_we", 64'(write_enabled), 64'h0);
        chk("rst_wdata", 64'(write_data), 64'h0);
        req_valid = '0;
        do_reset();

        // 1: single request from requester 1
        req_valid      = 3'b010;
        req_address[1] = 5'd5;
        req_strobe[1]  = 4'hF;
        req_data[1]    = 32'hDEADBEEF;
        #1;
        chk("t1_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        chk("t1_we", 64'(write_enabled), 64'h1);
        chk("t1_addr", 64'(write_address), 64'h5);
        chk("t1_strb", 64'(write_strobe), 64'hF);
        chk("t1_data", 64'(write_data), 64'hDEADBEEF);
        tick();
        chk("t1_we_idle", 64'(write_enabled), 64'h0);

        // 2: all three requesting for 6 cycles from a fresh pointer
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_address[i] = 5'(i + 1);
            req_strobe[i]  = 4'hF;
            req_data[i]    = 32'h1000 + 32'(i);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("t2_ready%0d", c), 64'(req_ready), 64'(1 << (c % 3)));
            tick();
            chk($sformatf("t2_we%0d", c), 64'(write_enabled), 64'h1);
            chk($sformatf("t2_addr%0d", c), 64'(write_address), 64'((c % 3) + 1));
        end
        req_valid = '0;
        tick();
        chk("t2_we_idle", 64'(write_enabled), 64'h0);

        // 3: reserve r7, query it, then write it
        reserve_valid   = 1'b1;
        reserve_address = 5'd7;
        tick();
        reserve_valid   = 1'b0;
        query_address_1 = 5'd7;
        query_address_2 = 5'd0;
        #1;
        chk("t3_qp1", 64'(query_pending_1), 64'h1);
        chk("t3_qp2_r0", 64'(query_pending_2), 64'h0);
        req_valid      = 3'b001;
        req_address[0] = 5'd7;
        req_strobe[0]  = 4'h3;
        req_data[0]    = 32'h77;
        #1;
        chk("t3_qp1_nobypass", 64'(query_pending_1), 64'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t3_qp1_clr", 64'(query_pending_1), 64'h0);
        chk("t3_addr", 64'(write_address), 64'h7);
        chk("t3_strb", 64'(write_strobe), 64'h3);

        // 4: reserve and write r9 on the same edge; set wins
        reserve_valid   = 1'b1;
        reserve_address = 5'd9;
        req_valid       = 3'b001;
        req_address[0]  = 5'd9;
        req_strobe[0]   = 4'hF;
        #1;
        chk("t4_noconf", 64'(reserve_conflict), 64'h0);
        tick();
        req_valid       = '0;
        reserve_valid   = 1'b0;
        query_address_1 = 5'd9;
        #1;
        chk("t4_pending9", 64'(query_pending_1), 64'h1);
        reserve_valid = 1'b1;
        #1;
        chk("t4_conflict", 64'(reserve_conflict), 64'h1);
        tick();
        reserve_valid = 1'b0;

        // 5: r0 write and zero-strobe write are both suppressed; r3 still clears
        reserve_valid   = 1'b1;
        reserve_address = 5'd3;
        tick();
        reserve_valid   = 1'b0;
        query_address_1 = 5'd3;
        #1;
        chk("t5_pending3", 64'(query_pending_1), 64'h1);
        req_valid      = 3'b001;
        req_address[0] = 5'd0;
        req_strobe[0]  = 4'hF;
        tick();
        chk("t5_we_r0", 64'(write_enabled), 64'h0);
        req_address[0] = 5'd3;
        req_strobe[0]  = 4'h0;
        tick();
        req_valid = '0;
        #1;
        chk("t5_we_s0", 64'(write_enabled), 64'h0);
        chk("t5_addr_cap", 64'(write_address), 64'h3);
        chk("t5_pending3_clr", 64'(query_pending_1), 64'h0);

        // 6: async reset with a write in flight and three pending bits
        for (int r = 10; r < 13; r++) begin
            reserve_valid   = 1'b1;
            reserve_address = 5'(r);
            tick();
        end
        reserve_valid   = 1'b0;
        req_valid       = 3'b010;
        req_address[1]  = 5'd4;
        req_strobe[1]   = 4'hF;
        req_data[1]     = 32'hCAFE0004;
        tick();
        req_valid       = '0;
        query_address_1 = 5'd10;
        query_address_2 = 5'd11;
        #1;
        chk("t6_we_pre", 64'(write_enabled), 64'h1);
        chk("t6_qp1_pre", 64'(query_pending_1), 64'h1);
        chk("t6_qp2_pre", 64'(query_pending_2), 64'h1);
        reset_n   = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("t6_we_rst", 64'(write_enabled), 64'h0);
        chk("t6_data_rst", 64'(write_data), 64'h0);
        chk("t6_addr_rst", 64'(write_address), 64'h0);
        chk("t6_qp1_rst", 64'(query_pending_1), 64'h0);
        chk("t6_qp2_rst", 64'(query_pending_2), 64'h0);
        chk("t6_ready_rst", 64'(req_ready), 64'h0);
        query_address_1 = 5'd12;
        #1;
        chk("t6_qp12_rst", 64'(query_pending_1), 64'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("t6_ptr0", 64'(req_ready), 64'h1);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
